// File: rtl/mul_by_2_n_seq_pkg.sv
// Shared types and helpers for mul_by_2_n_seq: FSM state encoding and the
// sign-loss test used by the one-bit shift step.
package mul_by_2_n_seq_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StShift = 2'b01,
      StDone  = 2'b10
   } state_e;

   // A left shift loses sign or magnitude when the two top bits disagree.
   function automatic logic sign_loss(input logic msb, input logic msb_m1);
      return msb ^ msb_m1;
   endfunction

endpackage

// File: rtl/mul_by_2_n_seq.sv
// Sequential in * 2^n, one shift per clock, with overflow flag.
// Define MUL_BY_2_N_SAT_EN to saturate (early exit) on overflow instead of wrapping.
module mul_by_2_n_seq
   import mul_by_2_n_seq_pkg::*;
#(
   parameter int unsigned W     = 64,
   parameter int unsigned LOG2W = 6,
   parameter int unsigned LOG2N = 6
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [LOG2N-1:0] n,
   input  logic [W-1:0]     in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out,
   output logic             ovf
);

   state_e           state_q, state_d;
   logic [W-1:0]     acc_q, acc_d;
   logic [LOG2N-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   // Shifts done so far; caps the wrapping mode at W shifts when n >= W.
   logic [LOG2W:0]   sh_q, sh_d;
`ifdef MUL_BY_2_N_SAT_EN
   logic             sign_q, sign_d;
`endif

   logic             loss;
   logic             last_shift;

   assign loss       = sign_loss(acc_q[W-1], acc_q[W-2]);
   assign last_shift = (cnt_q == LOG2N'(1)) || (sh_q == (LOG2W+1)'(W-1));

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      sh_d    = sh_q;
`ifdef MUL_BY_2_N_SAT_EN
      sign_d  = sign_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               acc_d   = in;
               cnt_d   = n;
               ovf_d   = 1'b0;
               sh_d    = '0;
`ifdef MUL_BY_2_N_SAT_EN
               sign_d  = in[W-1];
`endif
               state_d = ((n == '0) || (in == '0)) ? StDone : StShift;
            end
         end
         StShift: begin
`ifdef MUL_BY_2_N_SAT_EN
            if (loss) begin
               ovf_d   = 1'b1;
               state_d = StDone;
            end else begin
               acc_d = {acc_q[W-2:0], 1'b0};
               cnt_d = cnt_q - LOG2N'(1);
               sh_d  = sh_q + (LOG2W+1)'(1);
               if (last_shift) state_d = StDone;
            end
`else
            ovf_d = ovf_q | loss;
            acc_d = {acc_q[W-2:0], 1'b0};
            cnt_d = cnt_q - LOG2N'(1);
            sh_d  = sh_q + (LOG2W+1)'(1);
            if (last_shift) state_d = StDone;
`endif
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= StIdle;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         sh_q    <= '0;
`ifdef MUL_BY_2_N_SAT_EN
         sign_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         sh_q    <= sh_d;
`ifdef MUL_BY_2_N_SAT_EN
         sign_q  <= sign_d;
`endif
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign ovf       = ovf_q;

`ifdef MUL_BY_2_N_SAT_EN
   // Clamp toward the sign captured at accept: 0111..1 or 1000..0.
   assign out = ovf_q ? {sign_q, {(W-1){~sign_q}}} : acc_q;
`else
   assign out = acc_q;
`endif

endmodule
